// File: rtl/alu_op_scheduler_if.sv
// rtl/alu_op_scheduler_if.sv - request, T1/T2/ALU control and response bundle for alu_op_scheduler
interface alu_op_scheduler_if #(
    parameter int word_width   = 32,
    parameter int opcode_width = 4,
    parameter int flag_width   = 5
);
    logic [1:0]                  req_valid;
    logic [1:0]                  req_ready;
    logic [2*opcode_width-1:0]   req_opcode;
    logic [2*word_width-1:0]     req_a;
    logic [2*word_width-1:0]     req_b;
    logic [1:0]                  req_carry;
    logic [word_width-1:0]       t1_in;
    logic [word_width-1:0]       t2_in;
    logic                        t1_we;
    logic                        t2_we;
    logic                        t1_oe;
    logic                        t2_oe;
    logic                        alu_oe;
    logic [opcode_width-1:0]     alu_opcode;
    logic                        alu_carry;
    logic [word_width-1:0]       alu_out;
    logic [flag_width-1:0]       alu_flags;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic                        rsp_id;
    logic [word_width-1:0]       rsp_result;
    logic [flag_width-1:0]       rsp_flags;

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, req_carry,
        input  alu_out, alu_flags, rsp_ready,
        output req_ready, t1_in, t2_in, t1_we, t2_we, t1_oe, t2_oe,
        output alu_oe, alu_opcode, alu_carry,
        output rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_opcode, req_a, req_b, req_carry,
        output alu_out, alu_flags, rsp_ready,
        input  req_ready, t1_in, t2_in, t1_we, t2_we, t1_oe, t2_oe,
        input  alu_oe, alu_opcode, alu_carry,
        input  rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - round-robin scheduler sharing T1/T2 and the ALU between two requesters
module alu_op_scheduler #(
    parameter int word_width   = 32,
    parameter int opcode_width = 4,
    parameter int flag_width   = 5
) (
    input logic               clk,
    input logic               rst,
    alu_op_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic                    grant;
    logic                    accept;
    logic [1:0]              ready;
    logic                    load_en;
    logic                    exec_en;
    logic [opcode_width-1:0] op_opcode;
    logic [word_width-1:0]   op_a;
    logic [word_width-1:0]   op_b;
    logic                    op_carry;
    logic                    op_id;
    logic [word_width-1:0]   result_q;
    logic [flag_width-1:0]   flags_q;

    // req_ready is also held low while rst is asserted so every output reads 0 during reset
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        ready      = 2'b00;
        load_en    = 1'b0;
        exec_en    = 1'b0;
        case (state)
            IDLE: begin
                grant = (bus.req_valid == 2'b11) ? ~last_grant : bus.req_valid[1];
                if (rst && (bus.req_valid != 2'b00)) begin
                    accept     = 1'b1;
                    ready      = grant ? 2'b10 : 2'b01;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                exec_en    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_opcode  <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_carry   <= 1'b0;
            op_id      <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_id      <= grant;
                last_grant <= grant;
                op_opcode  <= grant ? bus.req_opcode[2*opcode_width-1:opcode_width]
                                    : bus.req_opcode[opcode_width-1:0];
                op_a       <= grant ? bus.req_a[2*word_width-1:word_width] : bus.req_a[word_width-1:0];
                op_b       <= grant ? bus.req_b[2*word_width-1:word_width] : bus.req_b[word_width-1:0];
                op_carry   <= grant ? bus.req_carry[1] : bus.req_carry[0];
            end
            if (state == EXEC) begin
                result_q <= bus.alu_out;
                flags_q  <= bus.alu_flags;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.t1_in      = op_a;
    assign bus.t2_in      = op_b;
    assign bus.t1_we      = load_en;
    assign bus.t2_we      = load_en;
    assign bus.t1_oe      = exec_en;
    assign bus.t2_oe      = exec_en;
    assign bus.alu_oe     = exec_en;
    assign bus.alu_opcode = op_opcode;
    assign bus.alu_carry  = op_carry;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = op_id;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb/tb_alu_op_scheduler.sv - scoreboard bench for alu_op_scheduler with T1/T2/ALU environment model
module tb_alu_op_scheduler;
    localparam int WW = 32;
    localparam int OW = 4;
    localparam int FW = 5;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;

    typedef struct packed {logic [3:0] opcode; logic [31:0] a; logic [31:0] b; logic carry;} op_t;
    typedef struct packed {logic id; logic [31:0] result; logic [4:0] flags;} exp_t;
    typedef struct {logic id; logic [31:0] result; logic [4:0] flags; int cyc;} got_t;
    typedef struct {logic id; int cyc;} acc_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    op_t  q0[$];
    op_t  q1[$];
    exp_t sb_q[$];
    got_t got_q[$];
    acc_t acc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_op_scheduler_if #(.word_width(WW), .opcode_width(OW), .flag_width(FW)) bus ();

    alu_op_scheduler #(.word_width(WW), .opcode_width(OW), .flag_width(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // flags: [0] carry, [1] zero, [2] negative, [3] overflow, [4] parity
    function automatic logic [36:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] s;
        logic [31:0] r;
        logic co, ov;
        s = '0; co = 1'b0; ov = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, c};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            OP_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return {^r, ov, r[31], (r == 32'd0), co, r};
    endfunction

    // T1/T2 registers and ALU around the scheduler
    logic [31:0] t1_q = '0;
    logic [31:0] t2_q = '0;
    logic [36:0] alu_res;
    always @(posedge clk) begin
        if (bus.t1_we) t1_q <= bus.t1_in;
        if (bus.t2_we) t2_q <= bus.t2_in;
    end
    always_comb alu_res = alu_f(bus.alu_opcode, t1_q, t2_q, bus.alu_carry);
    assign bus.alu_out   = (bus.alu_oe && bus.t1_oe && bus.t2_oe) ? alu_res[31:0]  : '0;
    assign bus.alu_flags = (bus.alu_oe && bus.t1_oe && bus.t2_oe) ? alu_res[36:32] : '0;

    function automatic op_t mk_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                  input logic c);
        op_t o;
        o.opcode = opc; o.a = a; o.b = b; o.carry = c;
        return o;
    endfunction

    function automatic exp_t mk_exp(input logic id, input op_t o);
        logic [36:0] r;
        exp_t e;
        r = alu_f(o.opcode, o.a, o.b, o.carry);
        e.id = id; e.result = r[31:0]; e.flags = r[36:32];
        return e;
    endfunction

    task automatic drive_req(input int i, input op_t o, input logic v);
        if (i == 0) begin
            bus.req_opcode[3:0] = o.opcode; bus.req_a[31:0] = o.a;
            bus.req_b[31:0] = o.b; bus.req_carry[0] = o.carry; bus.req_valid[0] = v;
        end else begin
            bus.req_opcode[7:4] = o.opcode; bus.req_a[63:32] = o.a;
            bus.req_b[63:32] = o.b; bus.req_carry[1] = o.carry; bus.req_valid[1] = v;
        end
    endtask

    // Drives the q0/q1 ops with rsp_ready=1, pushing the scoreboard on each accept and logging responses
    task automatic run_ops(input int max_cyc, output bit timed_out);
        int n_exp;
        int c;
        logic [1:0] acc;
        got_t g;
        acc_t a;
        n_exp = q0.size() + q1.size();
        c = 0;
        bus.rsp_ready = 1'b1;
        got_q.delete();
        acc_q.delete();
        while (got_q.size() < n_exp && c < max_cyc) begin
            if (q0.size() > 0) drive_req(0, q0[0], 1'b1); else bus.req_valid[0] = 1'b0;
            if (q1.size() > 0) drive_req(1, q1[0], 1'b1); else bus.req_valid[1] = 1'b0;
            #1;
            acc = bus.req_valid & bus.req_ready;
            if (bus.rsp_valid && bus.rsp_ready) begin
                g.id = bus.rsp_id; g.result = bus.rsp_result; g.flags = bus.rsp_flags; g.cyc = cyc;
                got_q.push_back(g);
            end
            if (acc[0]) begin
                a.id = 1'b0; a.cyc = cyc; acc_q.push_back(a);
                sb_q.push_back(mk_exp(1'b0, q0[0])); void'(q0.pop_front());
            end
            if (acc[1]) begin
                a.id = 1'b1; a.cyc = cyc; acc_q.push_back(a);
                sb_q.push_back(mk_exp(1'b1, q1[0])); void'(q1.pop_front());
            end
            @(negedge clk);
            c++;
        end
        bus.req_valid = 2'b00;
        timed_out = (got_q.size() < n_exp);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.req_valid = 2'b11; bus.req_opcode = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_carry = 2'b00; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00)
            $display("FAIL reset_req_ready: got %b want 00", bus.req_ready);
        n_checks++;
        if ({bus.rsp_valid, bus.t1_we, bus.t2_we, bus.t1_oe, bus.t2_oe, bus.alu_oe} !== 6'b0) begin
            n_errors++; $display("FAIL reset_enables: got %b want 000000",
                {bus.rsp_valid, bus.t1_we, bus.t2_we, bus.t1_oe, bus.t2_oe, bus.alu_oe});
        end
        n_checks++;
        if ({bus.t1_in, bus.t2_in, bus.rsp_result, bus.rsp_flags, bus.alu_opcode, bus.alu_carry, bus.rsp_id} !== '0) begin
            n_errors++; $display("FAIL reset_data: t1_in %h t2_in %h rsp_result %h want all 0",
                bus.t1_in, bus.t2_in, bus.rsp_result);
        end
        if (bus.req_ready !== 2'b00) n_errors++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++; $display("FAIL first_grant: got %b want 01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00) begin
            n_errors++; $display("FAIL idle_no_valid: got %b want 00", bus.req_ready);
        end
    endtask

    task automatic test_contention;
        bit to;
        int bad;
        logic [3:0] order;
        exp_t e;
        @(negedge clk);
        q0.push_back(mk_op(OP_ADD, 32'd10, 32'd1, 1'b0));
        q0.push_back(mk_op(OP_XOR, 32'h0000F0F0, 32'h00000FF0, 1'b0));
        q1.push_back(mk_op(OP_SUB, 32'd100, 32'd3, 1'b0));
        q1.push_back(mk_op(OP_ADD, 32'h00001000, 32'h00002000, 1'b1));
        run_ops(60, to);
        n_checks++;
        if (to || acc_q.size() != 4) begin
            n_errors++; $display("FAIL contention_count: got %0d rsp %0d accepts want 4 4",
                got_q.size(), acc_q.size());
        end else begin
            order = {acc_q[0].id, acc_q[1].id, acc_q[2].id, acc_q[3].id};
            n_checks++;
            if (order !== 4'b0101) begin
                n_errors++; $display("FAIL contention_order: got %b want 0101", order);
            end
            bad = 0;
            for (int k = 0; k < 3; k++) if (acc_q[k+1].cyc - acc_q[k].cyc != 4) bad++;
            n_checks++;
            if (bad != 0) begin
                n_errors++; $display("FAIL contention_spacing: got %0d bad gaps want 0", bad);
            end
            for (int k = 0; k < 4; k++) begin
                e = sb_q.pop_front();
                n_checks++;
                if (got_q[k].id !== e.id || got_q[k].result !== e.result || got_q[k].flags !== e.flags ||
                    got_q[k].cyc - acc_q[k].cyc != 3) begin
                    n_errors++;
                    $display("FAIL contention_rsp%0d: got id %b res %h flg %b lat %0d want id %b res %h flg %b lat 3",
                        k, got_q[k].id, got_q[k].result, got_q[k].flags, got_q[k].cyc - acc_q[k].cyc,
                        e.id, e.result, e.flags);
                end
            end
        end
        sb_q.delete();
    endtask

    task automatic test_single_op;
        exp_t e;
        op_t o;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        o = mk_op(OP_ADD, 32'd5, 32'd6, 1'b0);
        drive_req(0, o, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++; $display("FAIL single_ready: got %b want 01", bus.req_ready);
        end
        sb_q.push_back(mk_exp(1'b0, o));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        n_checks++;
        if ({bus.t1_we, bus.t2_we, bus.alu_oe, bus.req_ready} !== 5'b11000 ||
            bus.t1_in !== 32'd5 || bus.t2_in !== 32'd6) begin
            n_errors++; $display("FAIL single_load: got we %b%b oe %b rdy %b t1 %h t2 %h want 11 0 00 5 6",
                bus.t1_we, bus.t2_we, bus.alu_oe, bus.req_ready, bus.t1_in, bus.t2_in);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.t1_oe, bus.t2_oe, bus.alu_oe, bus.t1_we, bus.rsp_valid} !== 5'b11100 ||
            bus.alu_opcode !== OP_ADD || bus.alu_carry !== 1'b0) begin
            n_errors++; $display("FAIL single_exec: got oe %b%b%b we %b rv %b opc %h want 111 0 0 0",
                bus.t1_oe, bus.t2_oe, bus.alu_oe, bus.t1_we, bus.rsp_valid, bus.alu_opcode);
        end
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd11 ||
            bus.rsp_flags !== e.flags) begin
            n_errors++; $display("FAIL single_rsp: got rv %b id %b res %h flg %b want 1 0 0000000b %b",
                bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.flags);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_rsp_clear: got %b want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure;
        op_t o1, o0;
        exp_t e;
        int w, bad;
        logic id_s;
        logic [31:0] res_s;
        logic [4:0] flg_s;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        o1 = mk_op(OP_ADD, 32'd20, 32'd22, 1'b0);
        o0 = mk_op(OP_AND, 32'hFF00FF00, 32'h0FF00FF0, 1'b1);
        drive_req(1, o1, 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b10) begin
            n_errors++; $display("FAIL bp_ready_req1: got %b want 10", bus.req_ready);
        end
        sb_q.push_back(mk_exp(1'b1, o1));
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        drive_req(0, o0, 1'b1);
        #1;
        w = 0;
        while (!bus.rsp_valid && w < 10) begin @(negedge clk); #1; w++; end
        n_checks++;
        if (!bus.rsp_valid) begin
            n_errors++; $display("FAIL bp_rsp_timeout: got rsp_valid 0 want 1");
        end
        id_s = bus.rsp_id; res_s = bus.rsp_result; flg_s = bus.rsp_flags;
        e = sb_q.pop_front();
        n_checks++;
        if (id_s !== e.id || res_s !== 32'd42 || flg_s !== e.flags) begin
            n_errors++; $display("FAIL bp_rsp: got id %b res %h flg %b want 1 0000002a %b",
                id_s, res_s, flg_s, e.flags);
        end
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== id_s || bus.rsp_result !== res_s ||
                bus.rsp_flags !== flg_s || bus.req_ready !== 2'b00) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_release: got rdy %b rv %b want 00 1", bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++; $display("FAIL bp_next_accept: got %b want 01", bus.req_ready);
        end
        sb_q.push_back(mk_exp(1'b0, o0));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        w = 0;
        while (!bus.rsp_valid && w < 10) begin @(negedge clk); #1; w++; end
        e = sb_q.pop_front();
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== e.id || bus.rsp_result !== e.result ||
            bus.rsp_flags !== e.flags) begin
            n_errors++; $display("FAIL bp_second_rsp: got rv %b id %b res %h flg %b want 1 %b %h %b",
                bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flags, e.id, e.result, e.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_exec;
        bit to;
        int stale;
        exp_t e;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        drive_req(0, mk_op(OP_ADD, 32'h55, 32'h11, 1'b1), 1'b1);
        #1;
        n_checks++;
        if (bus.req_ready !== 2'b01) begin
            n_errors++; $display("FAIL rx_accept: got %b want 01", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.alu_oe !== 1'b1) begin
            n_errors++; $display("FAIL rx_in_exec: got alu_oe %b want 1", bus.alu_oe);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.t1_we, bus.t2_we, bus.t1_oe, bus.t2_oe, bus.alu_oe, bus.req_ready} !== 8'b0 ||
            {bus.t1_in, bus.t2_in, bus.alu_opcode, bus.alu_carry, bus.rsp_result, bus.rsp_flags, bus.rsp_id} !== '0) begin
            n_errors++; $display("FAIL rx_async_clear: got rv %b oe %b t1 %h res %h want all 0",
                bus.rsp_valid, bus.alu_oe, bus.t1_in, bus.rsp_result);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.rsp_valid !== 1'b0) stale++;
            @(negedge clk);
        end
        n_checks++;
        if (stale != 0) begin
            n_errors++; $display("FAIL rx_stale_rsp: got %0d cycles with rsp_valid want 0", stale);
        end
        q1.push_back(mk_op(OP_ADD, 32'd7, 32'd1, 1'b0));
        run_ops(20, to);
        n_checks++;
        if (to) begin
            n_errors++; $display("FAIL rx_new_op_timeout: got 0 responses want 1");
        end else begin
            e = sb_q.pop_front();
            if (got_q[0].id !== 1'b1 || got_q[0].result !== 32'd8 || got_q[0].flags !== e.flags) begin
                n_errors++; $display("FAIL rx_new_op: got id %b res %h flg %b want 1 00000008 %b",
                    got_q[0].id, got_q[0].result, got_q[0].flags, e.flags);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_streaming;
        bit to;
        int bad;
        exp_t e;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) q1.push_back(mk_op(OP_ADD, k, k, 1'b0));
        run_ops(40, to);
        n_checks++;
        if (to) begin
            n_errors++; $display("FAIL stream_timeout: got %0d responses want 3", got_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                e = sb_q.pop_front();
                n_checks++;
                if (got_q[k].id !== 1'b1 || got_q[k].result !== 32'(2 * (k + 1)) || got_q[k].flags !== e.flags) begin
                    n_errors++; $display("FAIL stream_rsp%0d: got id %b res %h want 1 %h",
                        k, got_q[k].id, got_q[k].result, 32'(2 * (k + 1)));
                end
            end
            bad = 0;
            for (int k = 0; k < 2; k++) if (got_q[k+1].cyc - got_q[k].cyc != 4) bad++;
            n_checks++;
            if (bad != 0) begin
                n_errors++; $display("FAIL stream_spacing: got %0d bad gaps want 0", bad);
            end
        end
        sb_q.delete();
    endtask

    task automatic test_wrap_flags;
        bit to;
        exp_t e;
        @(negedge clk);
        q0.push_back(mk_op(OP_ADD, 32'hFFFFFFFF, 32'd1, 1'b0));
        run_ops(20, to);
        n_checks++;
        if (to) begin
            n_errors++; $display("FAIL wrap_timeout: got 0 responses want 1");
        end else begin
            e = sb_q.pop_front();
            if (got_q[0].result !== 32'd0 || got_q[0].flags !== 5'b00011 || got_q[0].flags !== e.flags ||
                got_q[0].id !== 1'b0) begin
                n_errors++; $display("FAIL wrap_rsp: got id %b res %h flg %b want 0 00000000 00011",
                    got_q[0].id, got_q[0].result, got_q[0].flags);
            end
        end
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_backpressure();
        test_reset_exec();
        test_streaming();
        test_wrap_flags();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
